// File: rtl/cpu_phase_seq_pkg.sv
// Phase codes and helpers shared by the mcpu instruction-phase sequencer.
// The first eight codes keep the values of the old 3-bit control FSM
// (zero-extended), so existing decoders of q keep working unchanged.
package cpu_phase_seq_pkg;

    localparam int PH_W = 4;

    localparam logic [PH_W-1:0] PH_IDLE  = 4'd0;
    localparam logic [PH_W-1:0] PH_OPCFT = 4'd1;
    localparam logic [PH_W-1:0] PH_OPLRD = 4'd2;
    localparam logic [PH_W-1:0] PH_OPLFT = 4'd3;
    localparam logic [PH_W-1:0] PH_ADRD  = 4'd4;
    localparam logic [PH_W-1:0] PH_EXERD = 4'd5;
    localparam logic [PH_W-1:0] PH_EXE   = 4'd6;
    localparam logic [PH_W-1:0] PH_LOAD  = 4'd7;
    localparam logic [PH_W-1:0] PH_PAUSE = 4'd8;
    localparam logic [PH_W-1:0] PH_FAULT = 4'd9;

    // Phases that wait on the memory handshake and are subject to the timeout.
    function automatic logic ph_is_waiting(input logic [PH_W-1:0] ph);
        return (ph == PH_OPLRD) || (ph == PH_EXERD) || (ph == PH_LOAD);
    endfunction

endpackage

// File: rtl/cpu_phase_seq_wait_timer.sv
// Consecutive-wait counter for the phase sequencer. Counts cycles in which
// the memory keeps a waiting phase held and flags the cycle that would reach
// MAX_WAIT held cycles. MAX_WAIT = 0 disables the expiry flag.
module cpu_phase_seq_wait_timer #(
    parameter int WAIT_W   = 5,
    parameter int MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_i,
    input  logic              inc_i,
    output logic [WAIT_W-1:0] count_o,
    output logic              expire_o
);

    localparam logic [WAIT_W-1:0] LAST = (MAX_WAIT == 0) ? '0 : WAIT_W'(MAX_WAIT - 1);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    // Clear wins over increment so a phase change always restarts the count.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = count_q + WAIT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign expire_o = (MAX_WAIT != 0) && inc_i && (count_q == LAST);

endmodule

// File: rtl/cpu_phase_seq.sv
// Instruction-phase sequencer for the mcpu core.
//
//  state | meaning
//  IDLE  | waiting for run
//  OPCFT | opcode fetch
//  OPLRD | operand read, wait on kp; operand-less opcodes skip to EXE
//  OPLFT | operand fetch
//  ADRD  | address read
//  EXERD | execute-read, wait on kp
//  EXE   | execute; retires unless memory holds (-> LOAD)
//  LOAD  | load completion, wait on kp, retires
//  PAUSE | single-step pause between instructions
//  FAULT | memory wait timed out or illegal code; left only by clr_fault
module cpu_phase_seq
    import cpu_phase_seq_pkg::*;
#(
    parameter int MAX_WAIT = 16,
    parameter int WAIT_W   = 5,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              hlt,
    input  logic              kp,
    input  logic              no_opl,
    input  logic              step_mode,
    input  logic              step,
    input  logic              clr_fault,
    output logic [PH_W-1:0]   q,
    output logic              busy,
    output logic              fault,
    output logic [WAIT_W-1:0] wait_cnt,
    output logic              retire,
    output logic [CNT_W-1:0]  retire_cnt
);

    logic [PH_W-1:0]  state_q, state_d;
    logic             retire_q, retire_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic [PH_W-1:0]  next_ph;
    logic             waiting;
    logic             wait_inc;
    logic             wait_clr;
    logic             wait_expire;

    assign waiting  = ph_is_waiting(state_q);
    assign wait_inc = waiting && kp;
    assign wait_clr = !waiting || (state_d != state_q);

    cpu_phase_seq_wait_timer #(
        .WAIT_W   (WAIT_W),
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (wait_clr),
        .inc_i    (wait_inc),
        .count_o  (wait_cnt),
        .expire_o (wait_expire)
    );

    // Next phase and retire decision; a normal kp=0 exit beats the timeout.
    always_comb begin
        state_d  = state_q;
        retire_d = 1'b0;
        next_ph  = step_mode ? PH_PAUSE : PH_OPCFT;
        case (state_q)
            PH_IDLE:  if (run) state_d = PH_OPCFT;
            PH_OPCFT: state_d = PH_OPLRD;
            PH_OPLRD: begin
                if (!kp)              state_d = no_opl ? PH_EXE : PH_OPLFT;
                else if (wait_expire) state_d = PH_FAULT;
            end
            PH_OPLFT: state_d = PH_ADRD;
            PH_ADRD:  state_d = kp ? PH_EXERD : PH_EXE;
            PH_EXERD: begin
                if (!kp)              state_d = PH_EXE;
                else if (wait_expire) state_d = PH_FAULT;
            end
            PH_EXE: begin
                if (hlt) begin
                    state_d  = PH_IDLE;
                    retire_d = 1'b1;
                end else if (!kp) begin
                    state_d  = next_ph;
                    retire_d = 1'b1;
                end else begin
                    state_d  = PH_LOAD;
                end
            end
            PH_LOAD: begin
                if (!kp) begin
                    state_d  = next_ph;
                    retire_d = 1'b1;
                end else if (wait_expire) begin
                    state_d  = PH_FAULT;
                end
            end
            PH_PAUSE: if (step || !step_mode) state_d = PH_OPCFT;
            PH_FAULT: if (clr_fault) state_d = PH_IDLE;
            default:  state_d = PH_FAULT;
        endcase
        retire_cnt_d = retire_d ? retire_cnt_q + CNT_W'(1) : retire_cnt_q;
    end

    // Phase, retire pulse and retire counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PH_IDLE;
            retire_q     <= 1'b0;
            retire_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            retire_q     <= retire_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign q          = state_q;
    assign busy       = !((state_q == PH_IDLE) || (state_q == PH_PAUSE) || (state_q == PH_FAULT));
    assign fault      = (state_q == PH_FAULT);
    assign retire     = retire_q;
    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_cpu_phase_seq.sv
// Self-checking bench for cpu_phase_seq: expected per-cycle outputs are
// queued as each cycle's stimulus is applied and compared after the edge.
module tb_cpu_phase_seq;
    import cpu_phase_seq_pkg::*;

    localparam int MAX_WAIT = 4;
    localparam int WAIT_W   = 5;
    localparam int CNT_W    = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              run, hlt, kp, no_opl, step_mode, step, clr_fault;
    logic [PH_W-1:0]   q;
    logic              busy, fault, retire;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  retire_cnt;

    typedef struct {
        logic [PH_W-1:0]   ph;
        logic [WAIT_W-1:0] w;
        logic              ret;
        logic [CNT_W-1:0]  rcnt;
    } exp_t;

    exp_t             sb[$];
    logic [CNT_W-1:0] exp_rcnt;
    int               n_cmp = 0;
    int               n_bad = 0;

    cpu_phase_seq #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W),
        .CNT_W    (CNT_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .hlt        (hlt),
        .kp         (kp),
        .no_opl     (no_opl),
        .step_mode  (step_mode),
        .step       (step),
        .clr_fault  (clr_fault),
        .q          (q),
        .busy       (busy),
        .fault      (fault),
        .wait_cnt   (wait_cnt),
        .retire     (retire),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [PH_W-1:0] ph, input logic [WAIT_W-1:0] w, input logic ret);
        exp_t e;
        if (ret) exp_rcnt = exp_rcnt + CNT_W'(1);
        e.ph   = ph;
        e.w    = w;
        e.ret  = ret;
        e.rcnt = exp_rcnt;
        sb.push_back(e);
    endtask

    task automatic compare_out(input string tag);
        exp_t e;
        logic exp_busy;
        if (sb.size() == 0) begin
            check({tag, "/sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        exp_busy = !((e.ph == PH_IDLE) || (e.ph == PH_PAUSE) || (e.ph == PH_FAULT));
        check({tag, "/q"},          32'(q),          32'(e.ph));
        check({tag, "/wait_cnt"},   32'(wait_cnt),   32'(e.w));
        check({tag, "/retire"},     32'(retire),     32'(e.ret));
        check({tag, "/retire_cnt"}, 32'(retire_cnt), 32'(e.rcnt));
        check({tag, "/busy"},       32'(busy),       32'(exp_busy));
        check({tag, "/fault"},      32'(fault),      32'(e.ph == PH_FAULT));
    endtask

    // One clock: queue the expected post-edge outputs, advance, compare.
    task automatic cyc(input string tag, input logic [PH_W-1:0] ph, input logic [WAIT_W-1:0] w,
                       input logic ret);
        push_exp(ph, w, ret);
        @(posedge clk);
        #1;
        compare_out(tag);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; hlt = 1'b0; kp = 1'b0; no_opl = 1'b0;
        step_mode = 1'b0; step = 1'b0; clr_fault = 1'b0;
        exp_rcnt = '0;

        #12;
        check("rst/q",          32'(q),          32'(PH_IDLE));
        check("rst/wait_cnt",   32'(wait_cnt),   32'd0);
        check("rst/retire",     32'(retire),     32'd0);
        check("rst/retire_cnt", 32'(retire_cnt), 32'd0);
        check("rst/busy",       32'(busy),       32'd0);
        check("rst/fault",      32'(fault),      32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cyc("idle_hold", PH_IDLE, 0, 0);

        // Full-operand instruction, zero wait states.
        run = 1'b1;
        cyc("t1", PH_OPCFT, 0, 0);
        run = 1'b0;
        cyc("t1", PH_OPLRD, 0, 0);
        cyc("t1", PH_OPLFT, 0, 0);
        cyc("t1", PH_ADRD,  0, 0);
        cyc("t1", PH_EXE,   0, 0);
        cyc("t1", PH_OPCFT, 0, 1);
        cyc("t1", PH_OPLRD, 0, 0);

        // Operand-less opcodes: 3-cycle loop.
        no_opl = 1'b1;
        cyc("t2", PH_EXE,   0, 0);
        cyc("t2", PH_OPCFT, 0, 1);
        cyc("t2", PH_OPLRD, 0, 0);
        cyc("t2", PH_EXE,   0, 0);
        cyc("t2", PH_OPCFT, 0, 1);
        cyc("t2", PH_OPLRD, 0, 0);
        no_opl = 1'b0;
        cyc("t2", PH_OPLFT, 0, 0);
        cyc("t2", PH_ADRD,  0, 0);

        // Held EXERD counts up, releases to EXE.
        kp = 1'b1;
        cyc("t3", PH_EXERD, 0, 0);
        cyc("t3", PH_EXERD, 1, 0);
        cyc("t3", PH_EXERD, 2, 0);
        cyc("t3", PH_EXERD, 3, 0);
        kp = 1'b0;
        cyc("t3", PH_EXE,   0, 0);

        // kp stuck in LOAD: FAULT after MAX_WAIT held cycles.
        kp = 1'b1;
        cyc("t4", PH_LOAD,  0, 0);
        cyc("t4", PH_LOAD,  1, 0);
        cyc("t4", PH_LOAD,  2, 0);
        cyc("t4", PH_LOAD,  3, 0);
        cyc("t4", PH_FAULT, 0, 0);
        run = 1'b1; step = 1'b1; hlt = 1'b1;
        cyc("t4_ignore", PH_FAULT, 0, 0);
        run = 1'b0; step = 1'b0; hlt = 1'b0; kp = 1'b0;
        clr_fault = 1'b1;
        cyc("t4_clr", PH_IDLE, 0, 0);
        clr_fault = 1'b0;

        // kp drops on the last allowed cycle: normal exit wins over timeout.
        run = 1'b1;
        cyc("t4b", PH_OPCFT, 0, 0);
        run = 1'b0; no_opl = 1'b1;
        cyc("t4b", PH_OPLRD, 0, 0);
        cyc("t4b", PH_EXE,   0, 0);
        kp = 1'b1;
        cyc("t4b", PH_LOAD,  0, 0);
        cyc("t4b", PH_LOAD,  1, 0);
        cyc("t4b", PH_LOAD,  2, 0);
        cyc("t4b", PH_LOAD,  3, 0);
        kp = 1'b0;
        cyc("t4b", PH_OPCFT, 0, 1);

        // hlt beats kp in EXE; then single-step pause.
        cyc("t5", PH_OPLRD, 0, 0);
        cyc("t5", PH_EXE,   0, 0);
        hlt = 1'b1; kp = 1'b1;
        cyc("t5_hlt", PH_IDLE, 0, 1);
        hlt = 1'b0; kp = 1'b0;
        step_mode = 1'b1; run = 1'b1;
        cyc("t5", PH_OPCFT, 0, 0);
        run = 1'b0;
        cyc("t5", PH_OPLRD, 0, 0);
        cyc("t5", PH_EXE,   0, 0);
        cyc("t5", PH_PAUSE, 0, 1);
        hlt = 1'b1;
        cyc("t5_pause", PH_PAUSE, 0, 0);
        cyc("t5_pause", PH_PAUSE, 0, 0);
        hlt = 1'b0; step = 1'b1;
        cyc("t5_step", PH_OPCFT, 0, 0);
        step = 1'b0;
        cyc("t5", PH_OPLRD, 0, 0);
        cyc("t5", PH_EXE,   0, 0);
        kp = 1'b1;
        cyc("t5", PH_LOAD,  0, 0);
        cyc("t5", PH_LOAD,  1, 0);
        kp = 1'b0;
        cyc("t5", PH_PAUSE, 0, 1);
        step_mode = 1'b0;
        cyc("t5_leave", PH_OPCFT, 0, 0);

        // Async reset while held in EXERD.
        no_opl = 1'b0;
        cyc("t6", PH_OPLRD, 0, 0);
        cyc("t6", PH_OPLFT, 0, 0);
        cyc("t6", PH_ADRD,  0, 0);
        kp = 1'b1;
        cyc("t6", PH_EXERD, 0, 0);
        cyc("t6", PH_EXERD, 1, 0);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_rst/q",          32'(q),          32'(PH_IDLE));
        check("t6_rst/wait_cnt",   32'(wait_cnt),   32'd0);
        check("t6_rst/retire",     32'(retire),     32'd0);
        check("t6_rst/retire_cnt", 32'(retire_cnt), 32'd0);
        check("t6_rst/busy",       32'(busy),       32'd0);
        exp_rcnt = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        kp = 1'b0;

        // Retire counter wraps after 2**CNT_W retires.
        no_opl = 1'b1; run = 1'b1;
        cyc("t6_wrap", PH_OPCFT, 0, 0);
        run = 1'b0;
        for (int i = 0; i < (1 << CNT_W); i++) begin
            cyc("t6_wrap", PH_OPLRD, 0, 0);
            cyc("t6_wrap", PH_EXE,   0, 0);
            cyc("t6_wrap", PH_OPCFT, 0, 1);
        end
        check("t6_wrap/zero", 32'(retire_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
